// File: rtl/sound_ctrl_latch.sv
// Sound control latch: decodes CPU writes to SND_ADDR and holds the control byte.
// It also times the explosion and shell one-shots that drive the analog sound mixer.
// Latency: outputs update on the clk edge after a write hit.
// Backpressure: none. Every hit is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst           system clock and synchronous active-high reset
//   clk_12KHz_en       one-cycle strobe; the time base for both one-shots
//   cpu_addr/we/din    CPU write port (16-bit address, 8-bit data)
//   sound_enable       D5          engine_rev_en  D4       led_out  D6
//   motor_en           D7 & D5     explo_ls       D0       shell_ls D2
//   explo_en/shell_en  one-shot outputs, fired by rising D1 / D3
//   reg_q              raw latched control byte
module sound_ctrl_latch #(
   parameter logic [15:0] SND_ADDR    = 16'h1840,
   parameter int          EXPLO_TICKS = 1536,
   parameter int          SHELL_TICKS = 384,
   parameter int          CNT_W       = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_12KHz_en,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_din,
   output logic        sound_enable,
   output logic        motor_en,
   output logic        engine_rev_en,
   output logic        explo_ls,
   output logic        explo_en,
   output logic        shell_ls,
   output logic        shell_en,
   output logic        led_out,
   output logic [7:0]  reg_q
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} os_state_t;

   // Channel 0 is explosion (trigger D1), channel 1 is shell (trigger D3).
   localparam int NCH = 2;
   localparam logic [CNT_W-1:0] EXPLO_LOAD = CNT_W'(EXPLO_TICKS);
   localparam logic [CNT_W-1:0] SHELL_LOAD = CNT_W'(SHELL_TICKS);

   logic [7:0]       ctrl;
   logic             hit;
   logic             kill;
   logic [NCH-1:0]   trig_new;
   logic [NCH-1:0]   trig_old;
   logic [NCH-1:0]   start;
   os_state_t        state     [NCH];
   os_state_t        state_nxt [NCH];
   logic [CNT_W-1:0] cnt       [NCH];
   logic [CNT_W-1:0] cnt_nxt   [NCH];

   assign hit      = cpu_we && (cpu_addr == SND_ADDR);
   // A write that clears D5 silences everything on the same edge the byte lands.
   assign kill     = hit && !cpu_din[5];
   assign trig_new = {cpu_din[3], cpu_din[1]};
   assign trig_old = {ctrl[3], ctrl[1]};
   // Only a 0->1 edge of a trigger bit fires, and only when the new byte keeps sound on.
   assign start    = {NCH{hit && cpu_din[5]}} & trig_new & ~trig_old;

   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         state_nxt[ch] = state[ch];
         cnt_nxt[ch]   = cnt[ch];
         if (kill) begin
            state_nxt[ch] = IDLE;
            cnt_nxt[ch]   = '0;
         end else if (start[ch]) begin
            // A fire reloads the counter even when a tick lands in the same cycle.
            state_nxt[ch] = ACTIVE;
            cnt_nxt[ch]   = (ch == 0) ? EXPLO_LOAD : SHELL_LOAD;
         end else if (state[ch] == ACTIVE && clk_12KHz_en) begin
            if (cnt[ch] <= CNT_W'(1)) begin
               state_nxt[ch] = IDLE;
               cnt_nxt[ch]   = '0;
            end else begin
               cnt_nxt[ch]   = cnt[ch] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= 8'h00;
         for (int ch = 0; ch < NCH; ch++) begin
            state[ch] <= IDLE;
            cnt[ch]   <= '0;
         end
      end else begin
         if (hit) begin
            ctrl <= cpu_din;
         end
         for (int ch = 0; ch < NCH; ch++) begin
            state[ch] <= state_nxt[ch];
            cnt[ch]   <= cnt_nxt[ch];
         end
      end
   end

   assign reg_q         = ctrl;
   assign sound_enable  = ctrl[5];
   assign motor_en      = ctrl[7] & ctrl[5];
   assign engine_rev_en = ctrl[4];
   assign explo_ls      = ctrl[0];
   assign shell_ls      = ctrl[2];
   assign led_out       = ctrl[6];
   assign explo_en      = (state[0] == ACTIVE);
   assign shell_en      = (state[1] == ACTIVE);

endmodule

// File: tb/tb_sound_ctrl_latch.sv
// Self-checking bench for sound_ctrl_latch: a table of single-cycle vectors,
// followed by hand-written sequences that measure one-shot pulse lengths in strobes.
module tb_sound_ctrl_latch;

   localparam logic [15:0] SND_ADDR = 16'h1840;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_12KHz_en;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_din;
   logic        sound_enable, motor_en, engine_rev_en, explo_ls, explo_en;
   logic        shell_ls, shell_en, led_out;
   logic [7:0]  reg_q;
   logic [7:0]  outs;

   int checks = 0;
   int errors = 0;

   sound_ctrl_latch dut (
      .clk           (clk),
      .rst           (rst),
      .clk_12KHz_en  (clk_12KHz_en),
      .cpu_addr      (cpu_addr),
      .cpu_we        (cpu_we),
      .cpu_din       (cpu_din),
      .sound_enable  (sound_enable),
      .motor_en      (motor_en),
      .engine_rev_en (engine_rev_en),
      .explo_ls      (explo_ls),
      .explo_en      (explo_en),
      .shell_ls      (shell_ls),
      .shell_en      (shell_en),
      .led_out       (led_out),
      .reg_q         (reg_q)
   );

   always #5 clk = ~clk;

   // Output bundle: [7]motor [6]led [5]sound [4]rev [3]shell_en [2]shell_ls [1]explo_en [0]explo_ls
   assign outs = {motor_en, led_out, sound_enable, engine_rev_en,
                  shell_en, shell_ls, explo_en, explo_ls};

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  din;
      logic        tk;
      logic [7:0]  exp_q;
      logic [7:0]  exp_o;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic [7:0] o;
   } sb_t;

   vec_t tbl [16];
   sb_t  sb  [$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock: present inputs, let the edge pass, leave outputs settled 1ns after it.
   task automatic cyc(input logic [15:0] a, input logic we, input logic [7:0] d, input logic tk);
      cpu_addr     = a;
      cpu_we       = we;
      cpu_din      = d;
      clk_12KHz_en = tk;
      @(posedge clk);
      #1;
      cpu_we       = 1'b0;
      clk_12KHz_en = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      cyc(SND_ADDR, 1'b1, d, 1'b0);
   endtask

   task automatic strobe();
      cyc(SND_ADDR, 1'b0, 8'h00, 1'b1);
      cyc(SND_ADDR, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic sb_check(input string nm);
      sb_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_reg_q"}, int'(reg_q), int'(e.q));
         chk({nm, "_outs"},  int'(outs),  int'(e.o));
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int gap;
      int hi;

      //          addr          we    din    tk    reg_q  outs
      tbl[0]  = '{SND_ADDR,     1'b1, 8'hA0, 1'b0, 8'hA0, 8'hA0};
      tbl[1]  = '{SND_ADDR + 1, 1'b1, 8'h00, 1'b0, 8'hA0, 8'hA0};
      tbl[2]  = '{SND_ADDR,     1'b0, 8'hFF, 1'b0, 8'hA0, 8'hA0};
      tbl[3]  = '{SND_ADDR,     1'b1, 8'h70, 1'b0, 8'h70, 8'h70};
      tbl[4]  = '{SND_ADDR,     1'b1, 8'h40, 1'b0, 8'h40, 8'h40};
      tbl[5]  = '{SND_ADDR,     1'b1, 8'h25, 1'b0, 8'h25, 8'h25};
      tbl[6]  = '{SND_ADDR,     1'b1, 8'h27, 1'b0, 8'h27, 8'h27};
      tbl[7]  = '{SND_ADDR,     1'b0, 8'h00, 1'b1, 8'h27, 8'h27};
      tbl[8]  = '{SND_ADDR,     1'b1, 8'h2F, 1'b0, 8'h2F, 8'h2F};
      tbl[9]  = '{SND_ADDR,     1'b1, 8'h0F, 1'b0, 8'h0F, 8'h05};
      tbl[10] = '{SND_ADDR,     1'b1, 8'h2F, 1'b0, 8'h2F, 8'h25};
      tbl[11] = '{SND_ADDR,     1'b1, 8'h20, 1'b0, 8'h20, 8'h20};
      tbl[12] = '{SND_ADDR,     1'b1, 8'h2A, 1'b1, 8'h2A, 8'h2A};
      tbl[13] = '{SND_ADDR,     1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
      tbl[14] = '{SND_ADDR,     1'b1, 8'hE0, 1'b0, 8'hE0, 8'hE0};
      tbl[15] = '{SND_ADDR,     1'b1, 8'h80, 1'b0, 8'h80, 8'h00};

      rst          = 1'b1;
      cpu_addr     = SND_ADDR;
      cpu_we       = 1'b0;
      cpu_din      = 8'h00;
      clk_12KHz_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_reg_q", int'(reg_q), 0);
      chk("reset_outs",  int'(outs),  0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         sb.push_back('{q: tbl[i].exp_q, o: tbl[i].exp_o});
         cyc(tbl[i].addr, tbl[i].we, tbl[i].din, tbl[i].tk);
         sb_check($sformatf("tbl%0d", i));
      end

      // Explosion pulse is exactly 1536 strobes; a mid-pulse 0x22 rewrite must not extend it.
      wr(8'h00);
      wr(8'h22);
      chk("s2_explo_start", int'(explo_en), 1);
      n = 0;
      while (explo_en && n < 3000) begin
         if (n == 500) wr(8'h22);
         strobe();
         n++;
      end
      chk("s2_explo_len", n, 1536);

      // Shell retrigger: 200 strobes, 0x20, 0x28 -> continuous, then 384 more strobes.
      wr(8'h00);
      wr(8'h28);
      chk("s3_shell_start", int'(shell_en), 1);
      gap = 0;
      for (int i = 0; i < 200; i++) begin
         strobe();
         if (!shell_en) gap++;
      end
      wr(8'h20);
      if (!shell_en) gap++;
      wr(8'h28);
      if (!shell_en) gap++;
      chk("s3_shell_continuous", gap, 0);
      n = 0;
      while (shell_en && n < 1000) begin
         strobe();
         n++;
      end
      chk("s3_shell_len", n, 384);

      // Clearing D5 mid-pulse kills the pulse and the motor; later strobes do not restart it.
      wr(8'h00);
      sb.push_back('{q: 8'hA2, o: 8'hA2});
      wr(8'hA2);
      sb_check("s4_start");
      repeat (10) strobe();
      sb.push_back('{q: 8'h03, o: 8'h01});
      wr(8'h03);
      sb_check("s4_kill");
      hi = 0;
      for (int i = 0; i < 2000; i++) begin
         strobe();
         if (explo_en || shell_en) hi++;
      end
      chk("s4_no_pulse", hi, 0);

      // Fire with a strobe in the same cycle loads the full count (no decrement).
      wr(8'h00);
      sb.push_back('{q: 8'h2A, o: 8'h2A});
      cyc(SND_ADDR, 1'b1, 8'h2A, 1'b1);
      sb_check("s5_both_start");
      n = 0;
      while (shell_en && n < 1000) begin
         strobe();
         n++;
      end
      chk("s5_shell_len", n, 384);
      chk("s5_explo_still_on", int'(explo_en), 1);
      sb.push_back('{q: 8'h2A, o: 8'h22});
      cyc(SND_ADDR + 1, 1'b1, 8'h00, 1'b0);
      sb_check("s5_wrong_addr");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("s5_rst_reg_q", int'(reg_q), 0);
      chk("s5_rst_outs",  int'(outs),  0);
      strobe();
      chk("s5_post_rst_outs", int'(outs), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
